// File: rtl/gravador_sequencia.sv
// Sequence recorder: captures one-hot key presses and writes them to a 16x4 RAM.
// Optional key debounce enabled by defining GRAVADOR_DEBOUNCE_EN.
module gravador_sequencia #(
  parameter int TIMEOUT_M  = 5000,
  parameter int TIMEOUT_N  = 13,
  parameter int DEBOUNCE_M = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       finalizar,
  input  logic [3:0] chaves,
  output logic       ram_we,
  output logic [3:0] ram_endereco,
  output logic [3:0] ram_dado,
  output logic [4:0] tamanho,
  output logic       gravando,
  output logic       pronto,
  output logic       erro_jogada,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PREPARACAO   = 4'd1,
    ESPERA       = 4'd2,
    REGISTRA     = 4'd3,
    GRAVA        = 4'd4,
    ESPERA_SOLTA = 4'd5,
    PROXIMO      = 4'd6,
    FIM_GRAVACAO = 4'd7,
    ERRO         = 4'd8,
    EST_TIMEOUT  = 4'd9
  } estado_t;

  localparam logic [TIMEOUT_N-1:0] TMR_LIM = TIMEOUT_N'(TIMEOUT_M - 1);

  estado_t              state_q, state_d;
  logic [3:0]           addr_q, addr_d;
  logic [4:0]           tam_q, tam_d;
  logic [3:0]           dado_q, dado_d;
  logic [TIMEOUT_N-1:0] tmr_q, tmr_d;
  logic                 any_q;
  logic                 rise;
  logic                 press;
  logic                 release_ok;

  // History is tracked in every state so a key held into espera is not a new press.
  assign rise = (|chaves) & ~any_q;

`ifdef GRAVADOR_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_M + 1);
  localparam logic [CW-1:0] DB_LIM = CW'(DEBOUNCE_M);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    val_q, val_d;

  always_comb begin
    cnt_d = '0;
    val_d = val_q;
    case (state_q)
      ESPERA: begin
        cnt_d = cnt_q;
        if (chaves == 4'd0) begin
          cnt_d = '0;
        end else if (rise || (cnt_q != '0 && chaves != val_q)) begin
          cnt_d = CW'(1);
          val_d = chaves;
        end else if (cnt_q != '0 && cnt_q < DB_LIM) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ESPERA_SOLTA: begin
        if (chaves != 4'd0)       cnt_d = '0;
        else if (cnt_q < DB_LIM)  cnt_d = cnt_q + CW'(1);
        else                      cnt_d = cnt_q;
      end
      default: cnt_d = '0;
    endcase
  end

  assign press      = (chaves != 4'd0) && (cnt_d == DB_LIM);
  assign release_ok = (cnt_d == DB_LIM);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      val_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
    end
  end
`else
  assign press      = rise;
  assign release_ok = (chaves == 4'd0);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tam_d   = tam_q;
    dado_d  = dado_q;
    tmr_d   = tmr_q;
    ram_we  = 1'b0;
    case (state_q)
      INICIAL: if (iniciar) state_d = PREPARACAO;
      PREPARACAO: begin
        addr_d  = '0;
        tam_d   = '0;
        tmr_d   = '0;
        state_d = ESPERA;
      end
      ESPERA: begin
        tmr_d = tmr_q + 1'b1;
        if (finalizar)             state_d = FIM_GRAVACAO;
        else if (press)            state_d = REGISTRA;
        else if (tmr_q == TMR_LIM) state_d = EST_TIMEOUT;
      end
      REGISTRA: begin
        dado_d  = chaves;
        state_d = $onehot(chaves) ? GRAVA : ERRO;
      end
      GRAVA: begin
        ram_we  = 1'b1;
        tam_d   = tam_q + 5'd1;
        state_d = ESPERA_SOLTA;
      end
      ESPERA_SOLTA: if (release_ok) state_d = PROXIMO;
      PROXIMO: begin
        // A full memory ends the recording instead of wrapping the address.
        if (tam_q == 5'd16) begin
          state_d = FIM_GRAVACAO;
        end else begin
          addr_d  = addr_q + 4'd1;
          tmr_d   = '0;
          state_d = ESPERA;
        end
      end
      FIM_GRAVACAO, ERRO, EST_TIMEOUT: if (iniciar) state_d = PREPARACAO;
      default: state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= INICIAL;
      addr_q  <= '0;
      tam_q   <= '0;
      dado_q  <= '0;
      tmr_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tam_q   <= tam_d;
      dado_q  <= dado_d;
      tmr_q   <= tmr_d;
      any_q   <= |chaves;
    end
  end

  assign ram_endereco = addr_q;
  assign ram_dado     = dado_q;
  assign tamanho      = tam_q;
  assign db_estado    = state_q;
  assign pronto       = (state_q == FIM_GRAVACAO);
  assign erro_jogada  = (state_q == ERRO);
  assign timeout      = (state_q == EST_TIMEOUT);
  assign gravando     = !(state_q inside {INICIAL, FIM_GRAVACAO, ERRO, EST_TIMEOUT});

endmodule

// File: tb/tb_gravador_sequencia.sv
// Directed bench for gravador_sequencia; RAM writes are matched against a scoreboard queue.
module tb_gravador_sequencia;
  localparam int TM = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       finalizar = 1'b0;
  logic [3:0] chaves = 4'd0;
  logic       ram_we;
  logic [3:0] ram_endereco, ram_dado;
  logic [4:0] tamanho;
  logic       gravando, pronto, erro_jogada, timeout;
  logic [3:0] db_estado;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_w;
  int         nxt_addr = 0;
  logic [3:0] v;

  always #5 clock = ~clock;

  gravador_sequencia #(.TIMEOUT_M(TM), .TIMEOUT_N(13), .DEBOUNCE_M(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .finalizar(finalizar),
    .chaves(chaves), .ram_we(ram_we), .ram_endereco(ram_endereco),
    .ram_dado(ram_dado), .tamanho(tamanho), .gravando(gravando),
    .pronto(pronto), .erro_jogada(erro_jogada), .timeout(timeout),
    .db_estado(db_estado)
  );

  // Every write pulse must match the oldest expected {address, data}.
  always @(negedge clock) begin
    if (ram_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write: observed addr %0d data %0h, expected no write",
               ram_endereco, ram_dado);
      end else begin
        exp_w = sb.pop_front();
        assert ({ram_endereco, ram_dado} === exp_w) else begin
          errors++;
          $error("FAIL write: observed addr %0d data %0h, expected addr %0d data %0h",
                 ram_endereco, ram_dado, exp_w[7:4], exp_w[3:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_st(input logic [3:0] st, input int lim);
    int k = 0;
    while (db_estado !== st && k < lim) begin
      step(1);
      k++;
    end
    chk($sformatf("state_%0d", st), 32'(db_estado), 32'(st));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},    32'(ram_we),       0);
    chk({tag, "_addr"},  32'(ram_endereco), 0);
    chk({tag, "_dado"},  32'(ram_dado),     0);
    chk({tag, "_tam"},   32'(tamanho),      0);
    chk({tag, "_grav"},  32'(gravando),     0);
    chk({tag, "_pronto"},32'(pronto),       0);
    chk({tag, "_erro"},  32'(erro_jogada),  0);
    chk({tag, "_tout"},  32'(timeout),      0);
    chk({tag, "_st"},    32'(db_estado),    0);
  endtask

  task automatic start();
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    chk("prep_state", 32'(db_estado), 1);
    chk("prep_grav", 32'(gravando), 1);
    step(1);
    chk("espera_state", 32'(db_estado), 2);
    chk("espera_tam", 32'(tamanho), 0);
    nxt_addr = 0;
  endtask

  task automatic press(input logic [3:0] val);
    chaves = val;
    if ($onehot(val)) begin
      sb.push_back({nxt_addr[3:0], val});
      nxt_addr++;
      wait_st(4'd5, 40);
      chaves = 4'd0;
      wait_st((nxt_addr == 16) ? 4'd7 : 4'd2, 40);
    end else begin
      wait_st(4'd8, 40);
      chaves = 4'd0;
    end
  endtask

  initial begin
    // Reset state
    step(2);
    check_zero("reset");
    reset = 1'b1;
    step(1);
    chk("idle_state", 32'(db_estado), 0);

    // Three presses then finalizar; first press also checks write latency
    start();
`ifndef GRAVADOR_DEBOUNCE_EN
    chaves = 4'b0001;
    sb.push_back({4'd0, 4'b0001});
    nxt_addr = 1;
    step(1);
    chk("lat_registra", 32'(db_estado), 3);
    step(1);
    chk("lat_we", 32'(ram_we), 1);
    wait_st(4'd5, 40);
    chaves = 4'd0;
    wait_st(4'd2, 40);
`else
    press(4'b0001);
`endif
    press(4'b0100);
    press(4'b1000);
    finalizar = 1'b1;
    step(1);
    finalizar = 1'b0;
    chk("fin_state", 32'(db_estado), 7);
    chk("fin_pronto", 32'(pronto), 1);
    chk("fin_tam", 32'(tamanho), 3);
    chk("fin_grav", 32'(gravando), 0);
    chk("fin_sb_empty", 32'(sb.size()), 0);

    // Sixteen presses fill the memory; a further press must not write
    start();
    for (int i = 0; i < 16; i++) begin
      v = 4'b0001 << $urandom_range(0, 3);
      press(v);
    end
    chk("full_pronto", 32'(pronto), 1);
    chk("full_tam", 32'(tamanho), 16);
    chaves = 4'b0010;
    step(10);
    chaves = 4'd0;
    step(2);
    chk("full_state", 32'(db_estado), 7);
    chk("full_sb_empty", 32'(sb.size()), 0);

    // Invalid (two-key) press
    start();
    press(4'b0001);
    press(4'b0110);
    chk("bad_erro", 32'(erro_jogada), 1);
    chk("bad_tam", 32'(tamanho), 1);
    chk("bad_pronto", 32'(pronto), 0);

    // Timeout after TM cycles in espera, counted from the return out of proximo
    start();
    press(4'b1000);
    step(TM - 1);
    chk("tout_still_espera", 32'(db_estado), 2);
    step(1);
    chk("tout_state", 32'(db_estado), 9);
    chk("tout_flag", 32'(timeout), 1);
    chk("tout_tam", 32'(tamanho), 1);
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    chk("tout_restart", 32'(db_estado), 1);
    step(1);
    chk("tout_tam_clear", 32'(tamanho), 0);
    nxt_addr = 0;

    // Key held for 50 cycles: one write, proximo only after release
    chaves = 4'b0010;
    sb.push_back({4'd0, 4'b0010});
    nxt_addr = 1;
    step(50);
    chk("hold_state", 32'(db_estado), 5);
    chk("hold_tam", 32'(tamanho), 1);
    chaves = 4'd0;
    wait_st(4'd2, 40);

    // finalizar beats a simultaneous press
    finalizar = 1'b1;
    chaves = 4'b0100;
    step(1);
    finalizar = 1'b0;
    chaves = 4'd0;
    chk("prio_state", 32'(db_estado), 7);
    chk("prio_tam", 32'(tamanho), 1);

    // Reset during grava aborts the recording
    start();
    chaves = 4'b0001;
    sb.push_back({4'd0, 4'b0001});
    wait_st(4'd4, 40);
    reset = 1'b0;
    step(1);
    check_zero("midreset");
    reset = 1'b1;
    chaves = 4'd0;
    step(1);
    chk("midreset_idle", 32'(db_estado), 0);
    start();
    press(4'b1000);
    chk("restart_tam", 32'(tamanho), 1);

`ifdef GRAVADOR_DEBOUNCE_EN
    // Short glitch shorter than the debounce window
    chaves = 4'b0001;
    step(2);
    chaves = 4'd0;
    step(6);
    chk("glitch_state", 32'(db_estado), 2);
    chk("glitch_tam", 32'(tamanho), 1);
`endif

    step(3);
    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait never resolves
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
